// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side monitor for the 6-state JK counter stream
// (0,1,2,4,5,6,0,...). It tracks the stream, locks after LOCK_CNT correct
// transitions and reports sequence errors and illegal codes (3, 7).
//
// Optional feature macro: SEQ_IDX_EN adds the seq_idx output, which gives the
// position of the last valid sample within the count cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | no reference yet; waiting for a legal code to start from
// SYNC   | following the stream and counting consecutive correct transitions
// LOCKED | locked to the stream; mismatches pulse err and bump err_cnt
module count_seq_checker #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       count_in,
  input  logic             valid,
  input  logic             clr_err,
  output logic             locked,
  output logic [2:0]       expected,
  output logic             err,
  output logic             illegal,
`ifdef SEQ_IDX_EN
  output logic [2:0]       seq_idx,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] LOCK_TC   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_TC = 3'(UNLOCK_CNT);

  state_e           state_q, state_d;
  logic [2:0]       good_q, good_d;
  logic [2:0]       bad_q, bad_d;
  logic [2:0]       exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             ill_q, ill_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic             is_ill;
  logic             match;
  logic [2:0]       good_inc;
  logic [2:0]       bad_inc;

  // Successor of a code in the counter cycle; illegal codes map to where the
  // counter would land after them.
  function automatic logic [2:0] next_code(input logic [2:0] x);
    logic [2:0] n;
    case (x)
      3'd0:    n = 3'd1;
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd4;
      3'd3:    n = 3'd4;
      3'd4:    n = 3'd5;
      3'd5:    n = 3'd6;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  assign is_ill   = (count_in == 3'd3) || (count_in == 3'd7);
  assign match    = valid && (count_in == exp_q);
  assign good_inc = good_q + 3'd1;
  assign bad_inc  = bad_q + 3'd1;

  // Next-state, lock counters, prediction and pulse generation.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    ill_d   = 1'b0;
    cnt_d   = cnt_q;
    if (valid) begin
      ill_d = is_ill;
      exp_d = next_code(count_in);
      case (state_q)
        ST_HUNT: begin
          if (!is_ill) begin
            state_d = ST_SYNC;
            good_d  = 3'd0;
          end
        end
        ST_SYNC: begin
          if (match) begin
            good_d = good_inc;
            if (good_inc == LOCK_TC) begin
              state_d = ST_LOCKED;
              bad_d   = 3'd0;
            end
          end else if (is_ill) begin
            state_d = ST_HUNT;
            good_d  = 3'd0;
          end else begin
            good_d = 3'd0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            bad_d = 3'd0;
          end else begin
            err_d = 1'b1;
            bad_d = bad_inc;
            if (bad_inc == UNLOCK_TC) begin
              state_d = ST_HUNT;
              good_d  = 3'd0;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
          good_d  = 3'd0;
          bad_d   = 3'd0;
        end
      endcase
    end
    // A clear coinciding with a new error still records that error.
    if (clr_err) begin
      cnt_d = err_d ? ERR_W'(1) : '0;
    end else if (err_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_HUNT;
      good_q   <= 3'd0;
      bad_q    <= 3'd0;
      exp_q    <= 3'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked   = locked_q;
  assign expected = exp_q;
  assign err      = err_q;
  assign illegal  = ill_q;
  assign err_cnt  = cnt_q;

`ifdef SEQ_IDX_EN
  logic [2:0] seq_q, seq_d;

  // Cycle position of the sample; both illegal codes report 7.
  always_comb begin
    seq_d = seq_q;
    if (valid) begin
      case (count_in)
        3'd0:    seq_d = 3'd0;
        3'd1:    seq_d = 3'd1;
        3'd2:    seq_d = 3'd2;
        3'd4:    seq_d = 3'd3;
        3'd5:    seq_d = 3'd4;
        3'd6:    seq_d = 3'd5;
        default: seq_d = 3'd7;
      endcase
    end
  end

  // Position register, updated only on valid samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_q <= 3'd0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign seq_idx = seq_q;
`endif

endmodule
